// File: rtl/divider_4_seq.sv
// divider_4_seq: 4-bit unsigned sequential divider by repeated subtraction.
// Ports:
//   i_CLK        clock; all state updates on its rising edge
//   i_RST        synchronous active-high reset
//   i_Start      division request, accepted only in IDLE
//   i_Dividend   4-bit unsigned dividend, sampled on the accepting edge
//   i_Divisor    4-bit unsigned divisor, sampled on the accepting edge
//   o_Busy       high while the subtraction loop runs (CALC)
//   o_Done       one-cycle completion pulse (DONE)
//   o_DivZero    last accepted request had a zero divisor
//   o_Quotient   registered quotient (4'hF on divide-by-zero)
//   o_Remainder  registered remainder (dividend on divide-by-zero)
module divider_4_seq (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_Start,
    input  logic [3:0] i_Dividend,
    input  logic [3:0] i_Divisor,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_DivZero,
    output logic [3:0] o_Quotient,
    output logic [3:0] o_Remainder
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] div_q, div_d;
    logic       dz_q, dz_d;

    // Bit 4 of the widened difference is the borrow: set means R < D.
    logic [4:0] diff;
    logic       borrow;

    assign diff   = {1'b0, rem_q} - {1'b0, div_q};
    assign borrow = diff[4];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    div_d = i_Divisor;
                    rem_d = i_Dividend;
                    quo_d = 4'd0;
                    dz_d  = 1'b0;
                    if (i_Divisor == 4'd0) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                        quo_d   = 4'hF;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Quotient cannot exceed 15 here, so the increment never wraps.
                if (!borrow) begin
                    rem_d = diff[3:0];
                    quo_d = quo_q + 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            rem_q   <= 4'd0;
            quo_q   <= 4'd0;
            div_q   <= 4'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
        end
    end

    assign o_Busy      = (state_q == S_CALC);
    assign o_Done      = (state_q == S_DONE);
    assign o_DivZero   = dz_q;
    assign o_Quotient  = quo_q;
    assign o_Remainder = rem_q;

endmodule

// File: tb/tb_divider_4_seq.sv
// tb_divider_4_seq: scoreboard bench for divider_4_seq.
// Directed vectors plus a back-to-back sweep of all operand pairs.
module tb_divider_4_seq;

    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_Start = 1'b0;
    logic [3:0] i_Dividend = 4'd0;
    logic [3:0] i_Divisor = 4'd0;
    logic       o_Busy;
    logic       o_Done;
    logic       o_DivZero;
    logic [3:0] o_Quotient;
    logic [3:0] o_Remainder;

    divider_4_seq dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_Start     (i_Start),
        .i_Dividend  (i_Dividend),
        .i_Divisor   (i_Divisor),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_DivZero   (o_DivZero),
        .o_Quotient  (o_Quotient),
        .o_Remainder (o_Remainder)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        int q;
        int r;
        int dz;
        int acc;
        int lat;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt = 0;

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per o_Done.
    always @(negedge i_CLK) begin
        exp_t e;
        if (i_RST) begin
            busy_cnt = 0;
        end else begin
            if (o_Busy) busy_cnt++;
            if (o_Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", int'(o_Quotient), e.q);
                    chk("remainder", int'(o_Remainder), e.r);
                    chk("divzero", int'(o_DivZero), e.dz);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic exp_t mk(input int a, input int b, input int acc);
        exp_t e;
        e.acc = acc;
        if (b == 0) begin
            e.q = 15; e.r = a; e.dz = 1; e.lat = 0; e.busy = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0;
            e.lat = a / b + 1; e.busy = a / b + 1;
        end
        return e;
    endfunction

    // Called at a falling edge; the request is accepted at the next rising edge.
    task automatic start_op(input int a, input int b, input bit push);
        i_Start = 1'b1;
        i_Dividend = 4'(a);
        i_Divisor = 4'(b);
        if (push) sb.push_back(mk(a, b, cyc + 1));
        @(negedge i_CLK);
        i_Start = 1'b0;
        i_Dividend = 4'($urandom_range(0, 15));
        i_Divisor = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge i_CLK);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge i_CLK);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, int'(o_Busy), 0);
        chk({name, "_done"}, int'(o_Done), 0);
        chk({name, "_dz"}, int'(o_DivZero), 0);
        chk({name, "_q"}, int'(o_Quotient), 0);
        chk({name, "_r"}, int'(o_Remainder), 0);
    endtask

    initial begin
        int lat;
        // Reset with i_Start held high: nothing may be accepted.
        i_Start = 1'b1;
        i_Dividend = 4'd9;
        i_Divisor = 4'd2;
        repeat (3) @(negedge i_CLK);
        chk_zero("reset");
        i_Start = 1'b0;
        i_RST = 1'b0;
        @(negedge i_CLK);
        chk_zero("post_reset");

        start_op(13, 4, 1'b1);
        wait_drain(40);
        repeat (3) @(negedge i_CLK);
        chk("hold_q", int'(o_Quotient), 3);
        chk("hold_r", int'(o_Remainder), 1);
        chk("hold_dz", int'(o_DivZero), 0);

        start_op(3, 5, 1'b1);
        wait_drain(40);
        start_op(15, 1, 1'b1);
        wait_drain(40);
        start_op(7, 0, 1'b1);
        wait_drain(40);
        repeat (2) @(negedge i_CLK);
        chk("hold_dz_set", int'(o_DivZero), 1);
        chk("hold_dz_q", int'(o_Quotient), 15);
        chk("hold_dz_r", int'(o_Remainder), 7);

        // Second request during CALC must be ignored.
        start_op(13, 4, 1'b1);
        i_Start = 1'b1;
        i_Dividend = 4'd9;
        i_Divisor = 4'd3;
        @(negedge i_CLK);
        i_Start = 1'b0;
        wait_drain(40);
        repeat (6) @(negedge i_CLK);

        // Reset during CALC aborts without o_Done.
        start_op(15, 1, 1'b0);
        repeat (4) @(negedge i_CLK);
        i_RST = 1'b1;
        @(negedge i_CLK);
        i_RST = 1'b0;
        chk_zero("abort");
        repeat (20) @(negedge i_CLK);
        chk_zero("abort_quiet");
        start_op(6, 2, 1'b1);
        wait_drain(40);

        // Back-to-back sweep with i_Start held high.
        i_Start = 1'b1;
        i_Dividend = 4'd0;
        i_Divisor = 4'd0;
        for (int i = 0; i < 256; i++) begin
            sb.push_back(mk(i / 16, i % 16, cyc + 1));
            lat = ((i % 16) == 0) ? 0 : (i / 16) / (i % 16) + 1;
            @(negedge i_CLK);
            if (i < 255) begin
                i_Dividend = 4'((i + 1) / 16);
                i_Divisor = 4'((i + 1) % 16);
            end else begin
                i_Start = 1'b0;
            end
            repeat (lat + 1) @(negedge i_CLK);
        end
        wait_drain(40);
        repeat (4) @(negedge i_CLK);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
